// File: rtl/disp_pkg.sv
// Shared types and constants for the BCD scan driver: blank code, converter states,
// and the helper used to check that the digit count can hold the largest input value.
package disp_pkg;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  typedef enum logic [1:0] {IDLE, CONV, DONE} conv_state_t;

  function automatic longint ceil_div10(input longint v);
    return (v + 64'sd9) / 64'sd10;
  endfunction

  // Decimal digits needed for 2^width-1, i.e. smallest D with 10^D >= 2^width.
  function automatic int min_digits(input int width);
    longint v;
    int     n;
    v = longint'(1) << width;
    n = 0;
    while (v > 64'sd1) begin
      v = ceil_div10(v);
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, WIDTH shifts per value,
// with a valid/ready load handshake and a one-cycle done strobe in the DONE state.
module bin2bcd_seq
  import disp_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [WIDTH-1:0]      i_data,
  output logic                  o_ready,
  output logic                  o_done,
  output logic [DIGITS*4-1:0]   o_bcd
);

  localparam int IW = $clog2(WIDTH + 1);

  conv_state_t         r_state;
  conv_state_t         w_next;
  logic [WIDTH-1:0]    r_bin;
  logic [DIGITS*4-1:0] r_bcd;
  logic [DIGITS*4-1:0] w_adj;
  logic [IW-1:0]       r_iter;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    o_ready = 1'b0;
    o_done  = 1'b0;
    case (r_state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) w_next = CONV;
      end
      CONV: begin
        if (r_iter == IW'(1)) w_next = DONE;
      end
      DONE: begin
        o_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Pre-shift correction: any nibble that would reach 10+ after doubling gets +3.
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5) w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_iter <= '0;
    end else if (r_state == IDLE && i_valid) begin
      r_bin  <= i_data;
      r_bcd  <= '0;
      r_iter <= IW'(WIDTH);
    end else if (r_state == CONV) begin
      {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
      r_iter         <= r_iter - IW'(1);
    end
  end

  assign o_bcd = r_bcd;

endmodule

// File: rtl/bcd_scan_driver.sv
// Binary-to-BCD display driver: holds the committed digits, scans them one at a time
// onto a common-anode bank, and blanks leading zeros above the least significant digit.
module bcd_scan_driver
  import disp_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DIGITS      = 5,
  parameter int REFRESH_DIV = 50000,
  parameter int LZ_BLANK    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  output logic              in_ready,
  output logic              conv_done,
  output logic [3:0]        digit,
  output logic [DIGITS-1:0] an
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  generate
    if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
      $error("bcd_scan_driver: DIGITS too small for WIDTH");
    end
  endgenerate

  logic                w_done;
  logic [DIGITS*4-1:0] w_bcd;
  logic [DIGITS*4-1:0] r_disp_bcd;
  logic                r_conv_done;
  logic [RW-1:0]       r_refresh;
  logic [SW-1:0]       r_sel;
  logic                w_upper_zero;
  logic [3:0]          w_code;

  bin2bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (in_valid),
    .i_data  (in_data),
    .o_ready (in_ready),
    .o_done  (w_done),
    .o_bcd   (w_bcd)
  );

  // The display keeps the previous value for the whole conversion; only DONE commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp_bcd  <= '0;
      r_conv_done <= 1'b0;
    end else begin
      r_conv_done <= w_done;
      if (w_done) r_disp_bcd <= w_bcd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_refresh <= '0;
      r_sel     <= '0;
    end else if (r_refresh == RW'(REFRESH_DIV - 1)) begin
      r_refresh <= '0;
      r_sel     <= (r_sel == SW'(DIGITS - 1)) ? '0 : r_sel + SW'(1);
    end else begin
      r_refresh <= r_refresh + RW'(1);
    end
  end

  // A digit is a leading zero when it and every more significant digit are zero.
  always_comb begin
    w_upper_zero = 1'b1;
    w_code       = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (SW'(i) == r_sel) w_code = r_disp_bcd[i*4 +: 4];
      if (i >= int'(r_sel) && r_disp_bcd[i*4 +: 4] != 4'h0) w_upper_zero = 1'b0;
    end
  end

  assign digit     = (LZ_BLANK != 0 && r_sel != '0 && w_upper_zero) ? DIGIT_BLANK : w_code;
  assign an        = ~(DIGITS'(1) << r_sel);
  assign conv_done = r_conv_done;

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Scoreboard bench for bcd_scan_driver with a short refresh period: expected frames are
// queued when a value is loaded and compared cycle by cycle once conv_done appears.
module tb_bcd_scan_driver;

  localparam int WIDTH       = 16;
  localparam int DIGITS      = 5;
  localparam int REFRESH_DIV = 4;
  localparam int FRAME       = DIGITS * REFRESH_DIV;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [WIDTH-1:0]  in_data = '0;
  logic              in_ready;
  logic              conv_done;
  logic [3:0]        digit;
  logic [DIGITS-1:0] an;

  logic [DIGITS*4-1:0] expQ[$];
  logic [DIGITS*4-1:0] curFrame;
  int                  vectors = 0;
  int                  miscompares = 0;
  int                  cycSinceReset;
  int                  sel;
  int                  latency;
  int                  readyLow;
  logic                found;
  logic [3:0]          expDig;
  logic [DIGITS-1:0]   expAn;
  logic                expDone;

  always #5 clk = ~clk;

  bcd_scan_driver #(
    .WIDTH       (WIDTH),
    .DIGITS      (DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .LZ_BLANK    (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .conv_done (conv_done),
    .digit     (digit),
    .an        (an)
  );

  // Reference scan position: clock edges since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cycSinceReset <= 0;
    else        cycSinceReset <= cycSinceReset + 1;
  end

  function automatic logic [DIGITS*4-1:0] expectedFrame(input int v);
    logic [DIGITS*4-1:0] f;
    int rem;
    rem = v;
    f = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (i > 0 && rem == 0) f[i*4 +: 4] = 4'hF;
      else                   f[i*4 +: 4] = 4'(rem % 10);
      rem = rem / 10;
    end
    return f;
  endfunction

  // Waits (bounded) for in_ready at a falling edge, then offers one value for one handshake.
  task applyStimulus(input int v);
    int guard;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1;
    in_data  = WIDTH'(v);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    expQ.push_back(expectedFrame(v));
  endtask

  // Returns at the falling edge where conv_done is seen, popping the scoreboard entry.
  task waitConvDone(output int lat, output int lowCnt, output logic seen);
    lat = 0;
    lowCnt = 0;
    seen = 1'b0;
    while (lat < 100 && !seen) begin
      @(negedge clk);
      if (conv_done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (in_ready === 1'b0) lowCnt++;
        @(posedge clk);
        lat++;
      end
    end
    if (seen && expQ.size() > 0) curFrame = expQ.pop_front();
  endtask

  task test_reset();
    @(negedge clk);
    vectors++;
    if (an !== 5'b11110 || digit !== 4'h0 || in_ready !== 1'b1 || conv_done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_values: got an=%b digit=%h ready=%b done=%b, want an=11110 digit=0 ready=1 done=0",
               an, digit, in_ready, conv_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    curFrame = expectedFrame(0);
    for (int c = 0; c < FRAME; c++) begin
      sel = (cycSinceReset / REFRESH_DIV) % DIGITS;
      expDig = curFrame[sel*4 +: 4];
      expAn = ~(5'b00001 << sel);
      vectors++;
      if (digit !== expDig || an !== expAn || conv_done !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_frame c=%0d: got digit=%h an=%b done=%b, want digit=%h an=%b done=0",
                 c, digit, an, conv_done, expDig, expAn);
      end
      @(negedge clk);
    end
  endtask

  task test_load();
    applyStimulus(1234);
    waitConvDone(latency, readyLow, found);
    vectors++;
    if (!found || latency != 17 || readyLow != 17 || in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL load_1234_timing: got seen=%b latency=%0d readyLow=%0d ready=%b, want seen=1 latency=17 readyLow=17 ready=1",
               found, latency, readyLow, in_ready);
    end
    for (int c = 0; c < FRAME; c++) begin
      sel = (cycSinceReset / REFRESH_DIV) % DIGITS;
      expDig = curFrame[sel*4 +: 4];
      expAn = ~(5'b00001 << sel);
      expDone = (c == 0);
      vectors++;
      if (digit !== expDig || an !== expAn || conv_done !== expDone) begin
        miscompares++;
        $display("[TB] FAIL load_1234_frame c=%0d: got digit=%h an=%b done=%b, want digit=%h an=%b done=%b",
                 c, digit, an, conv_done, expDig, expAn, expDone);
      end
      @(negedge clk);
    end
  endtask

  task test_extremes();
    int vals[2];
    vals[0] = 65535;
    vals[1] = 0;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(vals[k]);
      waitConvDone(latency, readyLow, found);
      vectors++;
      if (!found || latency != 17) begin
        miscompares++;
        $display("[TB] FAIL extreme_%0d_latency: got seen=%b latency=%0d, want seen=1 latency=17",
                 vals[k], found, latency);
      end
      for (int c = 0; c < FRAME; c++) begin
        sel = (cycSinceReset / REFRESH_DIV) % DIGITS;
        expDig = curFrame[sel*4 +: 4];
        expAn = ~(5'b00001 << sel);
        expDone = (c == 0);
        vectors++;
        if (digit !== expDig || an !== expAn || conv_done !== expDone) begin
          miscompares++;
          $display("[TB] FAIL extreme_%0d_frame c=%0d: got digit=%h an=%b done=%b, want digit=%h an=%b done=%b",
                   vals[k], c, digit, an, conv_done, expDig, expAn, expDone);
        end
        @(negedge clk);
      end
    end
  endtask

  task test_ignored_valid();
    applyStimulus(1234);
    repeat (5) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = WIDTH'(999);
    @(negedge clk);
    in_valid = 1'b0;
    waitConvDone(latency, readyLow, found);
    vectors++;
    if (!found) begin
      miscompares++;
      $display("[TB] FAIL ignore_done: got seen=%b, want seen=1", found);
    end
    for (int c = 0; c < 2 * FRAME; c++) begin
      sel = (cycSinceReset / REFRESH_DIV) % DIGITS;
      expDig = curFrame[sel*4 +: 4];
      expAn = ~(5'b00001 << sel);
      expDone = (c == 0);
      vectors++;
      if (digit !== expDig || an !== expAn || conv_done !== expDone) begin
        miscompares++;
        $display("[TB] FAIL ignore_frame c=%0d: got digit=%h an=%b done=%b, want digit=%h an=%b done=%b",
                 c, digit, an, conv_done, expDig, expAn, expDone);
      end
      @(negedge clk);
    end
    applyStimulus(999);
    waitConvDone(latency, readyLow, found);
    for (int c = 0; c < FRAME; c++) begin
      sel = (cycSinceReset / REFRESH_DIV) % DIGITS;
      expDig = curFrame[sel*4 +: 4];
      expAn = ~(5'b00001 << sel);
      expDone = (c == 0) ? found : 1'b0;
      vectors++;
      if (!found || digit !== expDig || an !== expAn || conv_done !== expDone) begin
        miscompares++;
        $display("[TB] FAIL load_999_frame c=%0d: got digit=%h an=%b done=%b, want digit=%h an=%b done=%b",
                 c, digit, an, conv_done, expDig, expAn, expDone);
      end
      @(negedge clk);
    end
  endtask

  task test_back_to_back();
    applyStimulus(42);
    waitConvDone(latency, readyLow, found);
    sel = (cycSinceReset / REFRESH_DIV) % DIGITS;
    expDig = curFrame[sel*4 +: 4];
    vectors++;
    if (!found || in_ready !== 1'b1 || digit !== expDig) begin
      miscompares++;
      $display("[TB] FAIL b2b_first: got seen=%b ready=%b digit=%h, want seen=1 ready=1 digit=%h",
               found, in_ready, digit, expDig);
    end
    applyStimulus(10000);
    waitConvDone(latency, readyLow, found);
    vectors++;
    if (!found || latency != 17) begin
      miscompares++;
      $display("[TB] FAIL b2b_latency: got seen=%b latency=%0d, want seen=1 latency=17", found, latency);
    end
    for (int c = 0; c < FRAME; c++) begin
      sel = (cycSinceReset / REFRESH_DIV) % DIGITS;
      expDig = curFrame[sel*4 +: 4];
      expAn = ~(5'b00001 << sel);
      expDone = (c == 0);
      vectors++;
      if (digit !== expDig || an !== expAn || conv_done !== expDone) begin
        miscompares++;
        $display("[TB] FAIL b2b_frame c=%0d: got digit=%h an=%b done=%b, want digit=%h an=%b done=%b",
                 c, digit, an, conv_done, expDig, expAn, expDone);
      end
      @(negedge clk);
    end
  endtask

  task test_reset_mid_conv();
    applyStimulus(4321);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    void'(expQ.pop_back());
    #1;
    vectors++;
    if (in_ready !== 1'b1 || conv_done !== 1'b0 || digit !== 4'h0 || an !== 5'b11110) begin
      miscompares++;
      $display("[TB] FAIL abort_reset: got ready=%b done=%b digit=%h an=%b, want ready=1 done=0 digit=0 an=11110",
               in_ready, conv_done, digit, an);
    end
    @(negedge clk);
    rst_n = 1'b1;
    curFrame = expectedFrame(0);
    for (int c = 0; c < 2 * FRAME; c++) begin
      sel = (cycSinceReset / REFRESH_DIV) % DIGITS;
      expDig = curFrame[sel*4 +: 4];
      expAn = ~(5'b00001 << sel);
      vectors++;
      if (digit !== expDig || an !== expAn || conv_done !== 1'b0 || in_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL abort_frame c=%0d: got digit=%h an=%b done=%b ready=%b, want digit=%h an=%b done=0 ready=1",
                 c, digit, an, conv_done, in_ready, expDig, expAn);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    $display("[TB] bcd_scan_driver bench, REFRESH_DIV=%0d", REFRESH_DIV);
    test_reset();
    test_load();
    test_extremes();
    test_ignored_valid();
    test_back_to_back();
    test_reset_mid_conv();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
